color_frame_classifier: RTL and testbench

- Downstream consumer of the 176x144 RGB332 frame buffer read stream, the same pixels the VGA path scans out.
- Counts red-dominant and blue-dominant pixels inside a configurable region of interest (ROI) over each frame.
- Issues a per-frame red/blue/none decision, debounced across consecutive frames.
- RESULT drives the treasure-colour GPIO lines (3'b110 red, 3'b111 blue).

---
 rtl/color_pkg.sv | 41 ++++
 rtl/rgb332_classifier.sv | 34 +++
 rtl/color_frame_classifier.sv | 171 +++++++++++++++++
 tb/tb_color_frame_classifier.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// -----------------------------------------------------------------------------
// color_pkg
// Shared definitions for the colour-frame classifier:
//   - RGB332 field slice positions {R[2:0], G[2:0], B[1:0]}
//   - RESULT codes driven onto the treasure-colour GPIO lines
//   - FSM state encoding for the frame accumulator
//   - 15-bit saturating counter type and increment helper
// -----------------------------------------------------------------------------
package color_pkg;

  // RGB332 field positions
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // A blue pixel may carry at most this much red
  localparam logic [2:0] BLUE_R_MAX = 3'd2;

  // RESULT codes
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_RED  = 3'b110;
  localparam logic [2:0] RES_BLUE = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam int CNT_W = 15;
  typedef logic [CNT_W-1:0] count_t;

  // Saturating increment; holds at all-ones
  function automatic count_t sat_inc(input count_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/rgb332_classifier.sv
// -----------------------------------------------------------------------------
// rgb332_classifier
// Combinational red/blue test of one RGB332 pixel. Shared between the frame
// classifier and the debug overlay so both agree on what "red" and "blue" mean.
//   PIXEL_IN  in  8  {R[2:0], G[2:0], B[1:0]}
//   IS_RED    out 1  R>=R_MIN, G<=G_MAX, B==0
//   IS_BLUE   out 1  B>=B_MIN, G<=G_MAX, R<=2
// The two outputs can never be high together: red needs R>=R_MIN (>2) and B==0,
// blue needs R<=2 and B>=B_MIN (>0).
// -----------------------------------------------------------------------------
module rgb332_classifier
  import color_pkg::*;
#(
  parameter logic [2:0] R_MIN = 3'd5,
  parameter logic [1:0] B_MIN = 2'd2,
  parameter logic [2:0] G_MAX = 3'd3
) (
  input  logic [7:0] PIXEL_IN,
  output logic       IS_RED,
  output logic       IS_BLUE
);

  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;

  assign r = PIXEL_IN[R_MSB:R_LSB];
  assign g = PIXEL_IN[G_MSB:G_LSB];
  assign b = PIXEL_IN[B_MSB:B_LSB];

  assign IS_RED  = (r >= R_MIN) && (g <= G_MAX) && (b == 2'd0);
  assign IS_BLUE = (b >= B_MIN) && (g <= G_MAX) && (r <= BLUE_R_MAX);

endmodule

// File: rtl/color_frame_classifier.sv
// -----------------------------------------------------------------------------
// color_frame_classifier
// Watches the frame-buffer read stream, counts red- and blue-dominant pixels
// inside a rectangular region of interest, and once per frame issues a
// red/blue/none decision that only reaches RESULT after N_CONFIRM identical
// consecutive decisions.
//   CLK           in   1  pixel clock
//   RESET_N       in   1  asynchronous active-low reset
//   FRAME_START   in   1  one-cycle pulse at start of frame (restarts counting)
//   PIXEL_VALID   in   1  PIXEL_IN/X/Y valid this cycle
//   PIXEL_IN      in   8  RGB332 pixel
//   PIXEL_X       in  10  column of PIXEL_IN
//   PIXEL_Y       in  10  row of PIXEL_IN
//   RESULT        out  3  000 none, 110 red, 111 blue (debounced)
//   RESULT_VALID  out  1  one-cycle pulse per completed frame decision
//   RED_COUNT     out 15  red count of the last completed frame
//   BLUE_COUNT    out 15  blue count of the last completed frame
// -----------------------------------------------------------------------------
module color_frame_classifier
  import color_pkg::*;
#(
  parameter int         WIDTH        = 176,
  parameter int         HEIGHT       = 144,
  parameter int         ROI_X0       = 24,
  parameter int         ROI_X1       = 151,
  parameter int         ROI_Y0       = 16,
  parameter int         ROI_Y1       = 127,
  parameter logic [2:0] R_MIN        = 3'd5,
  parameter logic [1:0] B_MIN        = 2'd2,
  parameter logic [2:0] G_MAX        = 3'd3,
  parameter logic [14:0] COUNT_THRESH = 15'd2000,
  parameter int         N_CONFIRM    = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FRAME_START,
  input  logic        PIXEL_VALID,
  input  logic [7:0]  PIXEL_IN,
  input  logic [9:0]  PIXEL_X,
  input  logic [9:0]  PIXEL_Y,
  output logic [2:0]  RESULT,
  output logic        RESULT_VALID,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT
);

  localparam int STREAK_W = $clog2(N_CONFIRM + 1);

  localparam logic [9:0]          X_LO       = 10'(ROI_X0);
  localparam logic [9:0]          X_HI       = 10'(ROI_X1);
  localparam logic [9:0]          Y_LO       = 10'(ROI_Y0);
  localparam logic [9:0]          Y_HI       = 10'(ROI_Y1);
  localparam logic [9:0]          X_LAST     = 10'(WIDTH - 1);
  localparam logic [9:0]          Y_LAST     = 10'(HEIGHT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(N_CONFIRM);

  state_t                state;
  count_t                red_acc;
  count_t                blue_acc;
  logic [2:0]            candidate;
  logic [STREAK_W-1:0]   streak;

  // ---------------------------------------------------------------------------
  // Per-pixel qualification
  // ---------------------------------------------------------------------------
  logic is_red;
  logic is_blue;
  logic in_roi;
  logic accept;
  logic is_last;

  rgb332_classifier #(
    .R_MIN (R_MIN),
    .B_MIN (B_MIN),
    .G_MAX (G_MAX)
  ) u_classifier (
    .PIXEL_IN (PIXEL_IN),
    .IS_RED   (is_red),
    .IS_BLUE  (is_blue)
  );

  // The in-frame terms keep stray coordinates out even if the ROI parameters
  // are ever set to reach past the frame edge.
  assign in_roi = (PIXEL_X >= X_LO) && (PIXEL_X <= X_HI) &&
                  (PIXEL_Y >= Y_LO) && (PIXEL_Y <= Y_HI) &&
                  (PIXEL_X <= X_LAST) && (PIXEL_Y <= Y_LAST);
  assign accept  = PIXEL_VALID && in_roi;
  assign is_last = PIXEL_VALID && (PIXEL_X == X_LAST) && (PIXEL_Y == Y_LAST);

  // ---------------------------------------------------------------------------
  // Frame decision and debounce bookkeeping (used only in DECIDE)
  // ---------------------------------------------------------------------------
  logic [2:0]          raw;
  logic [2:0]          next_candidate;
  logic [STREAK_W-1:0] next_streak;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    raw = RES_NONE;
    if (red_acc > blue_acc && red_acc >= COUNT_THRESH) begin
      raw = RES_RED;
    end else if (blue_acc > red_acc && blue_acc >= COUNT_THRESH) begin
      raw = RES_BLUE;
    end
  end

  always_comb begin
    next_candidate = raw;
    next_streak    = STREAK_W'(1);
    if (raw == candidate) begin
      next_streak = (streak == STREAK_MAX) ? streak : streak + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and all registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      red_acc      <= '0;
      blue_acc     <= '0;
      candidate    <= RES_NONE;
      streak       <= '0;
      RESULT       <= RES_NONE;
      RESULT_VALID <= 1'b0;
      RED_COUNT    <= '0;
      BLUE_COUNT   <= '0;
    end else begin
      RESULT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (FRAME_START) begin
            red_acc  <= '0;
            blue_acc <= '0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          // The last pixel outranks a coincident FRAME_START: it is counted
          // and the frame is closed.
          if (FRAME_START && !is_last) begin
            red_acc  <= '0;
            blue_acc <= '0;
          end else begin
            if (accept && is_red)  red_acc  <= sat_inc(red_acc);
            if (accept && is_blue) blue_acc <= sat_inc(blue_acc);
            if (is_last)           state    <= DECIDE;
          end
        end

        DECIDE: begin
          RED_COUNT    <= red_acc;
          BLUE_COUNT   <= blue_acc;
          candidate    <= next_candidate;
          streak       <= next_streak;
          if (next_streak == STREAK_MAX) RESULT <= next_candidate;
          RESULT_VALID <= 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_frame_classifier.sv
// -----------------------------------------------------------------------------
// tb_color_frame_classifier
// Drives frames into color_frame_classifier and compares its outputs with a
// reference model that tracks pixel counts per frame and the history of frame
// decisions (RESULT follows the value of the last N_CONFIRM decisions whenever
// they all agree).
// -----------------------------------------------------------------------------
module tb_color_frame_classifier;

  localparam int W      = 176;
  localparam int H      = 144;
  localparam int X0     = 24;
  localparam int X1     = 151;
  localparam int Y0     = 16;
  localparam int Y1     = 127;
  localparam int THRESH = 2000;
  localparam int NCONF  = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        PIXEL_VALID = 1'b0;
  logic [7:0]  PIXEL_IN = 8'h00;
  logic [9:0]  PIXEL_X = 10'd0;
  logic [9:0]  PIXEL_Y = 10'd0;
  logic [2:0]  RESULT;
  logic        RESULT_VALID;
  logic [14:0] RED_COUNT;
  logic [14:0] BLUE_COUNT;

  int n_compared   = 0;
  int n_mismatched = 0;

  color_frame_classifier dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .FRAME_START  (FRAME_START),
    .PIXEL_VALID  (PIXEL_VALID),
    .PIXEL_IN     (PIXEL_IN),
    .PIXEL_X      (PIXEL_X),
    .PIXEL_Y      (PIXEL_Y),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .RED_COUNT    (RED_COUNT),
    .BLUE_COUNT   (BLUE_COUNT)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_open;
  int m_red, m_blue;
  int m_red_count, m_blue_count, m_result;
  int m_pulses;
  int raw_hist[$];
  int seen_pulses = 0;

  // Count RESULT_VALID pulses 2 ns after each rising edge
  always @(posedge CLK) begin
    #2;
    if (RESULT_VALID === 1'b1) seen_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_red(input logic [7:0] p);
    return (p[7:5] >= 5) && (p[4:2] <= 3) && (p[1:0] == 0);
  endfunction

  function automatic bit m_is_blue(input logic [7:0] p);
    return (p[1:0] >= 2) && (p[4:2] <= 3) && (p[7:5] <= 2);
  endfunction

  function automatic bit m_in_roi(input int x, input int y);
    return x >= X0 && x <= X1 && y >= Y0 && y <= Y1;
  endfunction

  function automatic int m_decide(input int r, input int b);
    if (r > b && r >= THRESH) return 3'b110;
    if (b > r && b >= THRESH) return 3'b111;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_open = 0; m_red = 0; m_blue = 0;
    m_red_count = 0; m_blue_count = 0; m_result = 0;
    raw_hist.delete();
  endtask

  task automatic model_step(input bit fs, input bit v, input logic [7:0] p,
                            input int x, input int y);
    bit last;
    bit agree;
    int n;
    last = v && x == W - 1 && y == H - 1;
    if (m_open && v && m_in_roi(x, y) && (!fs || last)) begin
      if (m_is_red(p))  m_red++;
      if (m_is_blue(p)) m_blue++;
    end
    if (m_open && last) begin
      m_open = 0;
      m_red_count  = m_red;
      m_blue_count = m_blue;
      raw_hist.push_back(m_decide(m_red, m_blue));
      n = raw_hist.size();
      if (n >= NCONF) begin
        agree = 1;
        for (int i = n - NCONF; i < n; i++) if (raw_hist[i] != raw_hist[n-1]) agree = 0;
        if (agree) m_result = raw_hist[n-1];
      end
      m_pulses++;
    end else if (fs) begin
      m_open = 1; m_red = 0; m_blue = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input bit fs, input bit v, input logic [7:0] p,
                      input int x, input int y);
    @(negedge CLK);
    FRAME_START = fs;
    PIXEL_VALID = v;
    PIXEL_IN    = p;
    PIXEL_X     = 10'(x);
    PIXEL_Y     = 10'(y);
    model_step(fs, v, p, x, y);
  endtask

  function automatic logic [7:0] red_pix();
    return {3'(5 + $urandom_range(2)), 3'($urandom_range(3)), 2'b00};
  endfunction

  function automatic logic [7:0] blue_pix();
    return {3'($urandom_range(2)), 3'($urandom_range(3)), 2'(2 + $urandom_range(1))};
  endfunction

  // Closes the frame with the last pixel and checks the decision timing/outputs
  task automatic finish_frame(input string tag);
    send(0, 1, 8'($urandom), W - 1, H - 1);
    @(negedge CLK);
    FRAME_START = 0;
    PIXEL_VALID = 0;
    check({tag, "_valid_early"}, RESULT_VALID, 0);
    @(negedge CLK);
    check({tag, "_valid"}, RESULT_VALID, 1);
    check({tag, "_red_count"}, RED_COUNT, m_red_count);
    check({tag, "_blue_count"}, BLUE_COUNT, m_blue_count);
    check({tag, "_result"}, RESULT, m_result);
    @(negedge CLK);
    check({tag, "_valid_late"}, RESULT_VALID, 0);
    check({tag, "_pulses"}, seen_pulses, m_pulses);
  endtask

  // Shuffled mix of in-ROI red/blue/black pixels and red pixels outside the ROI
  // (rows of in-ROI pixels limited to y_hi), with occasional idle cycles.
  task automatic sparse_pixels(input int n_red, input int n_blue, input int n_out,
                               input int n_black, input int y_hi);
    int left;
    int k;
    left = n_red + n_blue + n_out + n_black;
    while (left > 0) begin
      if ($urandom_range(15) == 0) send(0, 0, red_pix(), X0 + 5, Y0 + 5);
      k = $urandom_range(left - 1);
      if (k < n_red) begin
        send(0, 1, red_pix(), X0 + $urandom_range(X1 - X0), Y0 + $urandom_range(y_hi - Y0));
        n_red--;
      end else if (k < n_red + n_blue) begin
        send(0, 1, blue_pix(), X0 + $urandom_range(X1 - X0), Y0 + $urandom_range(y_hi - Y0));
        n_blue--;
      end else if (k < n_red + n_blue + n_out) begin
        if ($urandom_range(1) == 0) send(0, 1, red_pix(), $urandom_range(X0 - 1), $urandom_range(H - 1));
        else                         send(0, 1, red_pix(), X0 + $urandom_range(X1 - X0), Y1 + 1 + $urandom_range(H - 2 - Y1));
        n_out--;
      end else begin
        send(0, 1, 8'h00, X0 + $urandom_range(X1 - X0), Y0 + $urandom_range(y_hi - Y0));
        n_black--;
      end
      left--;
    end
  endtask

  task automatic sparse_frame(input string tag, input int n_red, input int n_blue,
                              input int n_out, input int n_black);
    send(1, 0, 8'h00, 0, 0);
    sparse_pixels(n_red, n_blue, n_out, n_black, Y1);
    finish_frame(tag);
  endtask

  // bias: 0 red-heavy, 1 blue-heavy, 2 mixed. Coordinates sometimes land far
  // outside the frame.
  task automatic random_frame(input int bias);
    int k, x, y;
    logic [7:0] p;
    send(1, 0, 8'h00, 0, 0);
    repeat (3200) begin
      k = $urandom_range(99);
      case (bias)
        0:       p = (k < 82) ? red_pix() : (k < 90) ? blue_pix() : 8'($urandom);
        1:       p = (k < 82) ? blue_pix() : (k < 90) ? red_pix() : 8'($urandom);
        default: p = (k < 45) ? red_pix() : (k < 90) ? blue_pix() : 8'($urandom);
      endcase
      if ($urandom_range(9) < 8) begin
        x = X0 + $urandom_range(X1 - X0);
        y = Y0 + $urandom_range(Y1 - Y0);
      end else begin
        x = $urandom_range(1023);
        y = $urandom_range(1023);
        if (x == W - 1 && y == H - 1) x = 0;
      end
      send(0, $urandom_range(19) != 0, p, x, y);
    end
    finish_frame("rand");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bias;
    model_reset();
    m_pulses = 0;

    repeat (3) @(negedge CLK);
    check("rst_result", RESULT, 0);
    check("rst_valid", RESULT_VALID, 0);
    check("rst_red_count", RED_COUNT, 0);
    check("rst_blue_count", BLUE_COUNT, 0);
    RESET_N = 1'b1;

    // Last-pixel coordinates while idle: no decision
    send(0, 1, 8'hE0, W - 1, H - 1);
    send(0, 0, 8'h00, 0, 0);
    repeat (3) @(negedge CLK);
    check("idle_last_pulses", seen_pulses, m_pulses);

    // Full red ROI sweep
    send(1, 0, 8'h00, 0, 0);
    for (int y = Y0; y <= Y1; y++)
      for (int x = X0; x <= X1; x++)
        send(0, 1, 8'hE0, x, y);
    finish_frame("full_red");
    check("full_red_const", RED_COUNT, 14336);
    check("full_red_res1", RESULT, 3'b000);

    sparse_frame("red2", 2200, 0, 200, 100);
    check("red2_res", RESULT, 3'b000);
    sparse_frame("red3", 2200, 0, 200, 100);
    check("red3_res", RESULT, 3'b110);

    sparse_frame("blue1", 0, 2200, 0, 100);
    check("blue1_res", RESULT, 3'b110);
    sparse_frame("blue2", 0, 2200, 0, 100);
    check("blue2_res", RESULT, 3'b110);
    sparse_frame("blue3", 0, 2200, 0, 100);
    check("blue3_res", RESULT, 3'b111);

    // Threshold boundary
    sparse_frame("red1999", 1999, 0, 300, 200);
    check("red1999_count", RED_COUNT, 1999);
    check("red1999_res", RESULT, 3'b111);
    sparse_frame("red2000", 2000, 0, 300, 200);
    check("red2000_count", RED_COUNT, 2000);

    // Tie with extra red outside the ROI
    sparse_frame("tie", 2500, 2500, 400, 0);

    // Abort at row 70 then a complete red frame
    send(1, 0, 8'h00, 0, 0);
    sparse_pixels(1500, 100, 0, 0, 70);
    send(1, 1, 8'hE0, X0 + 3, 70);
    sparse_pixels(2200, 0, 100, 50, Y1);
    finish_frame("abort");

    // Asynchronous reset in the middle of a frame
    send(1, 0, 8'h00, 0, 0);
    sparse_pixels(500, 0, 0, 0, Y1);
    @(negedge CLK);
    FRAME_START = 0;
    PIXEL_VALID = 0;
    #3 RESET_N = 1'b0;
    #1;
    check("arst_result", RESULT, 0);
    check("arst_valid", RESULT_VALID, 0);
    check("arst_red_count", RED_COUNT, 0);
    check("arst_blue_count", BLUE_COUNT, 0);
    model_reset();
    @(negedge CLK);
    #2 RESET_N = 1'b1;
    sparse_pixels(300, 0, 0, 0, Y1);
    send(0, 1, 8'hE0, W - 1, H - 1);
    send(0, 0, 8'h00, 0, 0);
    repeat (3) @(negedge CLK);
    check("arst_nofs_pulses", seen_pulses, m_pulses);
    sparse_frame("after_rst", 2200, 0, 0, 0);

    // Random frames with runs of the same bias
    bias = 0;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(2) == 0) bias = $urandom_range(2);
      random_frame(bias);
    end

    check("final_pulses", seen_pulses, m_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete within 2 ms");
    $fatal(1, "timeout");
  end

endmodule
